dqm_frame_packer: RTL
=====================

Name: dqm_frame_packer

Overview:
- Sits directly downstream of the DQM serializer. Consumes its serial bit stream and payload gate, in which each frame is a 48-bit header followed by a gated block of payload bits.
- Verifies the 32-bit sync portion of the header and extracts the 16-bit DQM value.
- Packs payload bits MSB-first into words for the processor/packet interface, using a valid/ready handshake.
- Reports per-frame status and error flags.

Parameters:
- WORD_W, 32, output word width in bits; must be a power of 2 and at least 8.
- HDR_W, 48, header length in bits: sync word 0, sync word 1, DQM value, 16 bits each.
- CNT_W, 16, width of payload bit counter and of block_size.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- serial_in  in  1  serial bit stream from the DQM serializer, one bit per clk.
- gate_in  in  1  high exactly while serial_in carries payload bits.
- sync_word  in  32  expected header bits 47:16 ({frame_word_0, frame_word_1}).
- block_size  in  CNT_W  expected payload bits per frame; quasi-static.
- out_data  out  WORD_W  packed payload word, first bit received is in the MSB.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_last  out  1  marks the final word of a frame.
- out_nbits  out  log2(WORD_W)+1  number of valid bits in out_data; equals WORD_W except possibly on the last word.
- dqm_value  out  16  header bits 15:0 of the most recent frame.
- hdr_ok  out  1  sync match result of the most recent frame.
- frame_done  out  1  one-cycle pulse when a frame closes.
- length_err  out  1  most recent frame's payload count differed from block_size.
- overflow  out  1  sticky; a completed word was dropped because the output register was occupied.
- frame_count  out  16  number of frames closed since reset; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all outputs go to 0, FSM goes to IDLE, the header shift register and packing accumulator clear.
  - Reset mid-frame discards the partial frame; no frame_done is issued.
- Header capture: a 48-bit shift register takes serial_in every cycle while gate_in=0. Newest bit enters at the LSB.
- FSM states:
  - IDLE: wait for gate_in=1.
  - PAYLOAD: pack bits while gate_in=1.
  - FLUSH: emit the partial word and close the frame.
- IDLE->PAYLOAD on the first cycle with gate_in=1. In that same cycle:
  - hdr_ok <= (hdr[47:16] == sync_word);
  - dqm_value <= hdr[15:0];
  - the first payload bit (serial_in in this cycle) is packed;
  - the bit counter loads 1.
- In PAYLOAD, each cycle with gate_in=1 shifts serial_in into the accumulator at position WORD_W-1-fill and increments the counter.
  - When fill reaches WORD_W, the word moves to the output register with nbits=WORD_W and last=0.
  - If that completion coincides with gate_in falling next cycle, the word is still emitted as a full, non-last word; FLUSH then handles closure.
- PAYLOAD->FLUSH on the first cycle with gate_in=0. That bit is not payload; it shifts into the header register.
- FLUSH takes one cycle:
  - If fill>0: emit the accumulator with zero-padded low bits, out_nbits=fill, out_last=1.
  - If fill==0: amend out_last=1 on the word still pending in the output register. If none is pending, emit no word and just pulse frame_done.
  - Also pulse frame_done, set length_err <= (count != block_size), increment frame_count, and go to IDLE.
- Output register:
  - one entry; out_valid holds until out_ready.
  - A word completing while out_valid=1 && !out_ready is dropped and overflow is set. Overflow clears only on reset.
  - Completion in the same cycle as acceptance is not an overflow.
- Counter saturates at 2^CNT_W-1; saturation implies length_err.
- A gate pulse shorter than HDR_W cycles after the previous frame still evaluates the stale header, and hdr_ok reflects the comparison.
- Latency: a payload bit reaches out_data 1 cycle after the cycle in which it completes a word.

Decomposition:
- Shared package dqm_pkg holds:
  - HDR_W;
  - the FSM state encoding (IDLE=0, PAYLOAD=1, FLUSH=2);
  - default sync constants (16'hFE6B, 16'h2840).
- One sub-module: dqm_word_out_reg, the single-entry valid/ready holding register with overflow detection.

Test Plan:
- Header FE6B_2840_01A5 followed by 64 gated bits 0xDEADBEEF_12345678, block_size=64, out_ready=1:
  - words DEADBEEF (last=0) and 12345678 (last=1, nbits=32);
  - hdr_ok=1, dqm_value=16'h01A5, length_err=0, frame_done pulse, frame_count=1.
- 40 payload bits 0xCAFEBABE then 0xA5, block_size=40: words CAFEBABE and A5000000 with nbits=8, last=1.
- Header sync corrupted by one flipped bit (FE6A...): hdr_ok=0, payload still packed normally.
- out_ready=0 across 96 payload bits: first word held in out_data, later words dropped, overflow=1 sticky; accepting later emits the held word.
- Gate high 60 cycles with block_size=64: length_err=1, last word nbits=28.
- rst_n=0 for one cycle mid-payload: outputs zero, no frame_done, frame_count=0; the next full frame processes correctly.

Source files
------------

// File: rtl/dqm_pkg.sv
// dqm_pkg: shared constants for the DQM frame packer (header size, FSM encoding, default sync)
package dqm_pkg;
    localparam int HDR_W = 48;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [15:0] SYNC_WORD_0 = 16'hFE6B;
    localparam logic [15:0] SYNC_WORD_1 = 16'h2840;
endpackage

// File: rtl/dqm_word_out_reg.sv
// dqm_word_out_reg: single-entry valid/ready holding register with sticky overflow on dropped words
module dqm_word_out_reg
    import dqm_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int NB_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic [NB_W-1:0]   push_nbits,
    input  logic              push_last,
    input  logic              amend_last,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic [NB_W-1:0]   out_nbits,
    output logic              out_last,
    output logic              overflow
);
    logic last_q;
    // A frame closing on a word boundary marks the pending word last in the same cycle it may be taken
    assign out_last = last_q | (amend_last & out_valid);
    // Load when empty or draining this cycle; otherwise a new word is lost and flagged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_nbits <= '0;
            out_valid <= 1'b0;
            last_q    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push && (!out_valid || out_ready)) begin
                out_data  <= push_data;
                out_nbits <= push_nbits;
                last_q    <= push_last;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                last_q    <= 1'b0;
            end else if (amend_last && out_valid) begin
                last_q <= 1'b1;
            end
            if (push && out_valid && !out_ready)
                overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/dqm_frame_packer.sv
// dqm_frame_packer: checks the DQM frame header and packs gated payload bits MSB-first into words
module dqm_frame_packer #(
    parameter int WORD_W = 32,
    parameter int HDR_W  = dqm_pkg::HDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    serial_in,
    input  logic                    gate_in,
    input  logic [31:0]             sync_word,
    input  logic [CNT_W-1:0]        block_size,
    output logic [WORD_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [$clog2(WORD_W):0] out_nbits,
    output logic [15:0]             dqm_value,
    output logic                    hdr_ok,
    output logic                    frame_done,
    output logic                    length_err,
    output logic                    overflow,
    output logic [15:0]             frame_count
);
    import dqm_pkg::*;
    localparam int NB_W = $clog2(WORD_W) + 1;
    logic [1:0]        state;
    logic [HDR_W-1:0]  hdr;
    logic [WORD_W-1:0] acc, acc_nx, push_data;
    logic [NB_W-1:0]   fill, fill_nx, pos, push_nbits;
    logic [CNT_W-1:0]  cnt;
    logic              sat, full, push, amend;
    // Accumulator and fill are zero in IDLE, so the first payload bit uses the same insert path
    always_comb begin
        pos        = NB_W'(WORD_W - 1) - fill;
        acc_nx     = acc | ({{(WORD_W-1){1'b0}}, serial_in} << pos);
        fill_nx    = fill + 1'b1;
        full       = gate_in && state != ST_FLUSH && fill_nx == NB_W'(WORD_W);
        push       = full || (state == ST_FLUSH && fill != '0);
        push_data  = full ? acc_nx : acc;
        push_nbits = full ? NB_W'(WORD_W) : fill;
        amend      = fill == '0 && (state == ST_FLUSH || (state == ST_PAYLOAD && !gate_in));
    end
    // Header shifting, frame FSM, payload packing and per-frame status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hdr         <= '0;
            acc         <= '0;
            fill        <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
            hdr_ok      <= 1'b0;
            dqm_value   <= '0;
            frame_done  <= 1'b0;
            length_err  <= 1'b0;
            frame_count <= '0;
        end else begin
            if (!gate_in)
                hdr <= {hdr[HDR_W-2:0], serial_in};
            frame_done <= state == ST_FLUSH;
            if (state == ST_FLUSH) begin
                length_err  <= sat || cnt != block_size;
                frame_count <= frame_count + 16'd1;
                acc         <= '0;
                fill        <= '0;
                state       <= ST_IDLE;
            end else if (gate_in) begin
                if (state == ST_IDLE) begin
                    hdr_ok    <= hdr[HDR_W-1 -: 32] == sync_word;
                    dqm_value <= hdr[15:0];
                    cnt       <= CNT_W'(1);
                    sat       <= 1'b0;
                    state     <= ST_PAYLOAD;
                end else begin
                    cnt <= &cnt ? cnt : cnt + 1'b1;
                    sat <= sat | (&cnt);
                end
                acc  <= full ? '0 : acc_nx;
                fill <= full ? '0 : fill_nx;
            end else if (state == ST_PAYLOAD) begin
                state <= ST_FLUSH;
            end
        end
    end
    dqm_word_out_reg #(.WORD_W(WORD_W), .NB_W(NB_W)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .push_nbits (push_nbits),
        .push_last  (!full),
        .amend_last (amend),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_nbits  (out_nbits),
        .out_last   (out_last),
        .overflow   (overflow)
    );
endmodule
